// File: rtl/result_writer.sv
// Receive end of the result bus: buffers unthrottled C-tile beats in a FIFO and
// writes each one to memory at its row-major address, pulsing done after the last.
module result_writer #(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int BUS_WIDTH    = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           m,
  input  logic [15:0]           p,
  input  logic [BUS_WIDTH-1:0]  data_i,
  input  logic                  valid_i,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int E     = BUS_WIDTH / DATA_WIDTH;
  localparam int CPR   = ARRAY_WIDTH / E;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PW    = $clog2(FIFO_DEPTH);

  localparam logic [15:0] CHUNK_LAST = 16'(CPR - 1);
  localparam logic [15:0] ROW_LAST   = 16'(ARRAY_HEIGHT - 1);
  localparam logic [PW:0] CNT_FULL   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           p_q, tc_last, tr_last;
  logic [15:0]           chunk, r, tc, tr;

  logic [BUS_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;

  logic full, empty, push_req, push, pop, last, start_go;
  logic [31:0] row, col, elem;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign start_go = (state == IDLE) && start;
  assign push_req = (state == RUN) && valid_i;
  assign pop      = mem_wvalid && mem_wready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign last     = pop && (chunk == CHUNK_LAST) && (r == ROW_LAST) &&
                    (tc == tc_last) && (tr == tr_last);

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign mem_wvalid = (state == RUN) && !empty;
  assign mem_wdata  = mem_wvalid ? fifo_mem[rd_ptr] : '0;

  // Address tracks the head beat through the counters, so it is valid with mem_wvalid.
  always_comb begin
    row      = 32'(tr) * 32'(ARRAY_HEIGHT) + 32'(r);
    col      = 32'(tc) * 32'(ARRAY_WIDTH) + 32'(chunk) * 32'(E);
    elem     = row * 32'(p_q) + col;
    mem_addr = base_q + ADDR_WIDTH'(elem * 32'(BYTES));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      p_q      <= '0;
      tc_last  <= '0;
      tr_last  <= '0;
      chunk    <= '0;
      r        <= '0;
      tc       <= '0;
      tr       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (start_go) begin
      base_q   <= base_addr;
      p_q      <= p;
      tc_last  <= p / 16'(ARRAY_WIDTH) - 16'd1;
      tr_last  <= m / 16'(ARRAY_HEIGHT) - 16'd1;
      chunk    <= '0;
      r        <= '0;
      tc       <= '0;
      tr       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (push_req && full && !pop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (chunk == CHUNK_LAST) begin
          chunk <= '0;
          if (r == ROW_LAST) begin
            r <= '0;
            if (tc == tc_last) begin
              tc <= '0;
              tr <= tr + 16'd1;
            end else begin
              tc <= tc + 16'd1;
            end
          end else begin
            r <= r + 16'd1;
          end
        end else begin
          chunk <= chunk + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_i;
  end

endmodule
